// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/ack bus between the fetch controller and imem.
interface if_fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_ctrl_skid.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      wr_instr,
  input  logic [WIDTH-1:0] wr_pc,
  input  logic [WIDTH-1:0] wr_pc4,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
      pc4   <= '0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
      pc4   <= wr_pc4;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding imem request, redirect drop, skid on stall.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_D flagging fetches with PC_D[1:0] != 0.
module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [WIDTH-1:0] PC_Plus4_in,
  output logic             PC_en,
  output logic             PCsrc,
  output logic [WIDTH-1:0] PC_Target,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  if_fetch_ctrl_if.master  imem,
  input  logic             stall_D,
  output logic [31:0]      Instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PC_Plus4_D,
  output logic             valid_D
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic             misalign_D
`endif
);

  fetch_state_e     state, state_nxt;
  logic             req, ld_fetch, ld_skid, skid_push, skid_pop, id_clr;
  logic [WIDTH-1:0] addr, addr_q;

  logic [31:0]      skid_instr, id_instr_nxt;
  logic [WIDTH-1:0] skid_pc, skid_pc4, id_pc_nxt, id_pc4_nxt;
  logic             skid_full, id_vld_nxt;

  fetch_skid #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (skid_push),
    .pop      (skid_pop),
    .wr_instr (imem.imem_rdata),
    .wr_pc    (PC_in),
    .wr_pc4   (PC_Plus4_in),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .pc4      (skid_pc4),
    .full     (skid_full)
  );

  // Redirect always clears IF/ID; the data of an in-flight request is dropped via DROP.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = PC_in;
    ld_fetch  = 1'b0;
    ld_skid   = 1'b0;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    id_clr    = redirect_valid;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        req = 1'b1;
        if (redirect_valid) begin
          state_nxt = imem.imem_ack ? FETCH : DROP;
        end else if (imem.imem_ack) begin
          if (stall_D) begin
            skid_push = 1'b1;
            state_nxt = HOLD;
          end else begin
            ld_fetch = 1'b1;
          end
        end else if (!stall_D) begin
          id_clr = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_pop  = 1'b1;
          state_nxt = FETCH;
        end else if (!stall_D) begin
          ld_skid   = 1'b1;
          skid_pop  = 1'b1;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        req    = 1'b1;
        addr   = addr_q;
        id_clr = 1'b1;
        if (imem.imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign id_instr_nxt = ld_skid ? skid_instr : imem.imem_rdata;
  assign id_pc_nxt    = ld_skid ? skid_pc    : PC_in;
  assign id_pc4_nxt   = ld_skid ? skid_pc4   : PC_Plus4_in;
  assign id_vld_nxt   = ld_skid ? skid_full  : 1'b1;

  assign imem.imem_req  = !rst && req;
  assign imem.imem_addr = addr;
  assign PC_en          = !rst && (redirect_valid || (state == FETCH && imem.imem_ack));
  assign PCsrc          = !rst && redirect_valid;
  assign PC_Target      = redirect_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      valid_D    <= 1'b0;
      Instr_D    <= NOP_INSTR;
      PC_D       <= '0;
      PC_Plus4_D <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) addr_q <= PC_in;
      if (id_clr) begin
        valid_D <= 1'b0;
      end else if (ld_fetch || ld_skid) begin
        valid_D    <= id_vld_nxt;
        Instr_D    <= id_instr_nxt;
        PC_D       <= id_pc_nxt;
        PC_Plus4_D <= id_pc4_nxt;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                        misalign_D <= 1'b0;
    else if (id_clr)                misalign_D <= 1'b0;
    else if (ld_fetch || ld_skid)   misalign_D <= |id_pc_nxt[1:0];
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: behavioural imem + PC register, expected IF/ID stream queue.
module tb_if_fetch_ctrl;
  localparam int W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } fet_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_q, PC_in, PC_Plus4_in, PC_Target, redirect_target, PC_D, PC_Plus4_D;
  logic         PC_en, PCsrc, redirect_valid, stall_D, valid_D;
  logic [31:0]  Instr_D;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic         misalign_D;
`endif

  if_fetch_ctrl_if #(.WIDTH(W)) imem();

  always #5 clk = ~clk;

  // PC stage: advance by 4 or take the redirect target when enabled
  assign PC_in       = pc_q;
  assign PC_Plus4_in = pc_q + 32'd4;
  always_ff @(posedge clk) begin
    if (rst)        pc_q <= '0;
    else if (PC_en) pc_q <= PCsrc ? PC_Target : pc_q + 32'd4;
  end

  if_fetch_ctrl #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC_in           (PC_in),
    .PC_Plus4_in     (PC_Plus4_in),
    .PC_en           (PC_en),
    .PCsrc           (PCsrc),
    .PC_Target       (PC_Target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem.master),
    .stall_D         (stall_D),
    .Instr_D         (Instr_D),
    .PC_D            (PC_D),
    .PC_Plus4_D      (PC_Plus4_D),
    .valid_D         (valid_D)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_D      (misalign_D)
`endif
  );

  int          n_chk = 0, n_pass = 0;
  int          lat = 1, cnt = 0, retired = 0, r0;
  bit          rand_lat = 0, outst = 0, drop_pend = 0, in_hold = 0, inject = 0;
  bit          prev_bub = 0, prev_rv = 0;
  logic [31:0] req_addr = '0;
  fet_t        sb[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[24:0], 7'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, answer imem, check outputs, update scoreboard.
  task automatic cyc(input bit st, input bit rv, input logic [31:0] rt);
    bit   req, ack, exp_en;
    fet_t e;
    @(posedge clk); #1;
    stall_D = st; redirect_valid = rv; redirect_target = rt;
    ack = 1'b0; req = imem.imem_req; imem.imem_rdata = 32'hDEAD_BEEF;
    if (prev_bub || prev_rv) chk("bubble_vld", valid_D, 0);
    if (in_hold) begin
      chk("hold_noreq", req, 0);
      if (inject) begin ack = 1'b1; imem.imem_rdata = 32'h0BAD_0BAD; end
    end
    if (req) begin
      if (!outst) begin
        outst = 1'b1; cnt = 1; req_addr = imem.imem_addr;
        chk("req_addr", imem.imem_addr, pc_q);
        if (rand_lat) lat = $urandom_range(1, 4);
      end else begin
        cnt++;
        chk("addr_hold", imem.imem_addr, req_addr);
      end
      if (cnt >= lat) begin ack = 1'b1; imem.imem_rdata = mem_f(req_addr); end
    end
    imem.imem_ack = ack;
    #1;
    exp_en = rv | (ack & req & !drop_pend);
    chk("pc_en", PC_en, exp_en);
    chk("pcsrc", PCsrc, rv);
    chk("pc_target", PC_Target, rt);
    if (valid_D && !st) begin
      if (sb.size() == 0) chk("spurious_vld", valid_D, 0);
      else begin
        e = sb.pop_front();
        chk("pc_D", PC_D, e.pc);
        chk("instr_D", Instr_D, e.instr);
        chk("pc4_D", PC_Plus4_D, e.pc4);
        retired++;
      end
    end
    if (rv) sb.delete();
    if (in_hold && (!st || rv)) in_hold = 1'b0;
    if (ack && req) begin
      if (!rv && !drop_pend) begin
        sb.push_back('{pc: req_addr, instr: mem_f(req_addr), pc4: req_addr + 32'd4});
        if (st) in_hold = 1'b1;
      end
      outst = 1'b0; drop_pend = 1'b0;
    end else if (rv && outst) begin
      drop_pend = 1'b1;
    end
    prev_bub = req && !ack && !st;
    prev_rv  = rv;
  endtask

  task automatic do_reset(input bit late_ack);
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h44; stall_D = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0BAD_0BAD;
    #1;
    chk("rst_req", imem.imem_req, 0);
    chk("rst_pc_en", PC_en, 0);
    chk("rst_pcsrc", PCsrc, 0);
    @(posedge clk); #2;
    chk("rst_vld", valid_D, 0);
    chk("rst_instr", Instr_D, 32'h0000_0013);
    chk("rst_pc_D", PC_D, 0);
    chk("rst_pc4_D", PC_Plus4_D, 0);
    rst = 1'b0; redirect_valid = 1'b0; imem.imem_ack = late_ack;
    #1;
    chk("idle_req", imem.imem_req, 0);
    chk("idle_pc_en", PC_en, 0);
    sb.delete(); outst = 0; drop_pend = 0; in_hold = 0; prev_bub = 0; prev_rv = 0;
  endtask

  initial begin
    rst = 1'b1; stall_D = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    do_reset(1'b0);

    // single-cycle ack stream from PC 0
    lat = 1; retired = 0;
    repeat (6) cyc(0, 0, 0);
    chk("t1_retired", retired, 5);

    // three-cycle ack latency
    lat = 3; r0 = retired;
    repeat (10) cyc(0, 0, 0);
    chk("t2_progress", retired > r0, 1);

    // decode stall at the ack of 0x8, stray ack while holding
    do_reset(1'b0); lat = 1;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    inject = 1; cyc(1, 0, 0); inject = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("resume_addr", req_addr, 32'hC);
    repeat (4) cyc(0, 0, 0);

    // redirect to 0x100 while the 0x10 request is outstanding
    do_reset(1'b0); lat = 1;
    repeat (4) cyc(0, 0, 0);
    lat = 3;
    cyc(0, 0, 0);
    chk("drop_addr", req_addr, 32'h10);
    cyc(0, 1, 32'h100);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("redir_addr", req_addr, 32'h100);
    repeat (6) cyc(0, 0, 0);

    // redirect in the ack cycle
    do_reset(1'b0); lat = 2;
    cyc(0, 0, 0); cyc(0, 1, 32'h200);
    cyc(0, 0, 0);
    chk("ack_redir_addr", req_addr, 32'h200);
    repeat (5) cyc(0, 0, 0);

    // redirect while holding the skid entry
    do_reset(1'b0); lat = 1;
    cyc(1, 0, 0); cyc(1, 1, 32'h300);
    cyc(0, 0, 0);
    chk("hold_redir_addr", req_addr, 32'h300);
    repeat (4) cyc(0, 0, 0);

    // redirect overrides a stalled valid IF/ID entry
    do_reset(1'b0); lat = 2; r0 = retired;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 1, 32'h400);
    repeat (6) cyc(0, 0, 0);
    chk("t7_progress", retired > r0, 1);

    // reset in the middle of a request, late ack lands in IDLE
    do_reset(1'b0); lat = 4;
    cyc(0, 0, 0); cyc(0, 0, 0);
    do_reset(1'b1); lat = 1; r0 = retired;
    cyc(0, 0, 0);
    chk("post_rst_addr", req_addr, 32'h0);
    repeat (4) cyc(0, 0, 0);
    chk("t8_progress", retired > r0, 1);

    // random stalls, redirects and latencies
    rand_lat = 1; r0 = retired;
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom & 32'h0000_FFFC);
    rand_lat = 0; lat = 1;
    repeat (8) cyc(0, 0, 0);
    chk("rand_progress", retired > r0 + 20, 1);
    chk("sb_drain", sb.size() <= 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 PC_in  in  WIDTH  current PC from PC stage; PC_Plus4_in  in  WIDTH  PC+4 from PC stage.
REQ-006 PC_en  out  1  PC register enable; PCsrc  out  1  PC mux select; PC_Target  out  WIDTH  redirect address.
REQ-007 redirect_valid  in  1  and redirect_target  in  WIDTH: redirect request from execute.
REQ-008 imem_req  out  1, imem_addr  out  WIDTH, imem_ack  in  1 (single-cycle pulse, 1..N cycles after req), imem_rdata  in  32 (valid with ack).
REQ-009 stall_D  in  1  decode stall; Instr_D  out  32, PC_D  out  WIDTH, PC_Plus4_D  out  WIDTH, valid_D  out  1: IF/ID register.

Function
REQ-010 States SHALL be IDLE, FETCH, HOLD, DROP; IDLE moves to FETCH unconditionally on the next cycle.
REQ-011 At most one memory request SHALL be outstanding; imem_req high in FETCH and DROP only, held until the ack cycle inclusive.
REQ-012 imem_addr SHALL equal PC_in in FETCH and addr_q in DROP; addr_q loads PC_in every FETCH cycle.
REQ-013 PCsrc SHALL equal redirect_valid and PC_Target SHALL equal redirect_target combinationally.
REQ-014 PC_en SHALL be high when redirect_valid, or when imem_ack in FETCH; low otherwise.
REQ-015 FETCH, ack, no redirect, stall_D low: next cycle Instr_D=imem_rdata, PC_D=PC_in, PC_Plus4_D=PC_Plus4_in, valid_D=1; stay FETCH.
REQ-016 FETCH, ack, no redirect, stall_D high: capture into skid entry; go HOLD; IF/ID unchanged.
REQ-017 HOLD: no request; when stall_D low, skid moves to IF/ID (valid_D=1), go FETCH.
REQ-018 FETCH, no ack, no stall_D: valid_D SHALL go 0 next cycle (bubble); with stall_D high, IF/ID holds.
REQ-019 Redirect in FETCH without ack: go DROP. Redirect in FETCH with ack: discard data, stay FETCH.
REQ-020 DROP: on ack discard data, go FETCH; redirect in DROP stays DROP.
REQ-021 Redirect in HOLD: discard skid, go FETCH.
REQ-022 Redirect in any state SHALL clear valid_D next cycle, overriding stall_D.
REQ-023 imem_ack in IDLE or HOLD SHALL be ignored.

Reset
REQ-024 On rst: state IDLE, valid_D=0, Instr_D=32'h0000_0013, PC_D=0, PC_Plus4_D=0, skid empty, addr_q=0.
REQ-025 Outputs during reset: imem_req=0, PC_en=0, PCsrc=0; reset mid-request abandons it, late ack ignored per REQ-023.

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN: when defined, output misalign_D (1 bit, reset 0) SHALL be set with a fetched instruction whose PC_D[1:0]!=0, and a redirect with redirect_target[1:0]!=0 SHALL still be taken.
REQ-027 Without FETCH_MISALIGN_CHECK_EN the port and logic SHALL be absent; other behaviour identical.

Structure
REQ-028 Package fetch_pkg SHALL hold the state enum and NOP constant 32'h0000_0013.
REQ-029 Sub-module fetch_skid SHALL implement the one-entry skid buffer (instr, PC, PC+4, full flag).

Verification
REQ-030 Ack latency 1, PC_in=0x0, rdata=0x00500093 -> cycle after ack: Instr_D=0x00500093, PC_D=0, PC_Plus4_D=4, valid_D=1, PC_en pulse in ack cycle.
REQ-031 Ack latency 3 -> imem_req high 3 cycles, address stable, PC_en low until ack, valid_D=0 while waiting.
REQ-032 stall_D high at ack of PC=0x8 -> HOLD, no req; stall_D low 2 cycles later -> PC_D=0x8, valid_D=1, FETCH resumes at 0xC.
REQ-033 Redirect to 0x100 while request at 0x10 outstanding -> DROP, imem_addr stays 0x10, ack data discarded, next req addr 0x100.
REQ-034 Redirect same cycle as ack -> data discarded, valid_D=0, next req addr = target.
REQ-035 rst asserted mid-request then ack arrives -> ack ignored, all outputs at reset values, first req after IDLE.
